// File: rtl/bpu_btb_ras.sv
// -----------------------------------------------------------------------------
// bpu_btb_ras -- next-PC predictor for the 5-stage pipeline.
//
// A direct-mapped BTB holds a tag, a target and a saturating counter for
// each entry. A speculative return-address stack, with a committed shadow
// copy, predicts returns.
//
// The IF stage reads the predictor combinationally, with zero cycles of
// latency. The EX stage resolves control flow, trains the BTB, keeps the
// committed RAS up to date, and raises flush_o when the PC held in ID was
// the wrong one.
//
// Build option:
//   BPU_RAS_EN  When defined, both RAS copies are built and returns are
//               predicted from the speculative RAS top. When undefined,
//               there is no RAS storage and returns predict from the BTB
//               like any other jump.
//
// Ports:
//   clk          clock; all state updates happen on the rising edge
//   reset        asynchronous, active-high; clears valid bits, counters and
//                RAS pointers
//   stall_i      freezes every BTB, counter and RAS update
//   pc_if_i      PC being fetched
//   inst_if_i    instruction word at pc_if_i
//   pc_id_i      PC currently in ID, i.e. the prediction made for EX
//   ex_valid_i   EX holds a real instruction
//   pc_ex_i      PC of the EX instruction
//   inst_ex_i    instruction word in EX
//   br_target_i  resolved target of the EX branch or jump
//   br_taken_i   EX branch or jump is taken
//   next_pc_o    next fetch PC
//   flush_o      EX misprediction; flush IF/ID
// -----------------------------------------------------------------------------
module bpu_btb_ras #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 1024,
  parameter int CTR_BITS    = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_if_i,
  input  logic [31:0]     inst_if_i,
  input  logic [XLEN-1:0] pc_id_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [31:0]     inst_ex_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            br_taken_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            flush_o
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAG = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  // Weakly-taken and weakly-not-taken values, used when an entry is allocated.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic if_br, if_jal, if_jalr;
  logic ex_br, ex_jal, ex_jalr, ex_cf;

  assign if_br   = (inst_if_i[6:2] == OP_BR);
  assign if_jal  = (inst_if_i[6:2] == OP_JAL);
  assign if_jalr = (inst_if_i[6:2] == OP_JALR);
  assign ex_br   = (inst_ex_i[6:2] == OP_BR);
  assign ex_jal  = (inst_ex_i[6:2] == OP_JAL);
  assign ex_jalr = (inst_ex_i[6:2] == OP_JALR);
  assign ex_cf   = ex_br | ex_jal | ex_jalr;

  // Only the opcode, rd and rs1 fields carry meaning here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_if_i, inst_ex_i};

  // ---------------------------------------------------------------------------
  // BTB storage. Valid bits and counters are reset; tags and targets are not.
  // ---------------------------------------------------------------------------
  logic                btb_valid_reg [BTB_ENTRIES];
  logic [CTR_BITS-1:0] btb_ctr_reg   [BTB_ENTRIES];
  logic [TAG-1:0]      btb_tag_reg   [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_tgt_reg   [BTB_ENTRIES];

  logic [IDX-1:0] if_idx, ex_idx;
  logic [TAG-1:0] if_tag, ex_tag;
  logic           if_hit, ex_hit;

  assign if_idx = pc_if_i[IDX+1:2];
  assign if_tag = pc_if_i[XLEN-1:IDX+2];
  assign ex_idx = pc_ex_i[IDX+1:2];
  assign ex_tag = pc_ex_i[XLEN-1:IDX+2];
  assign if_hit = btb_valid_reg[if_idx] && (btb_tag_reg[if_idx] == if_tag);
  assign ex_hit = btb_valid_reg[ex_idx] && (btb_tag_reg[ex_idx] == ex_tag);

  // ---------------------------------------------------------------------------
  // Return-address stack (optional)
  // ---------------------------------------------------------------------------
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;
  logic            flush;

`ifdef BPU_RAS_EN
  localparam int SPW = $clog2(RAS_DEPTH);
  localparam logic [SPW:0] RAS_FULL = (SPW + 1)'(RAS_DEPTH);

  typedef struct packed {
    logic           wr;
    logic [SPW-1:0] widx;
    logic [SPW-1:0] sp;
    logic [SPW:0]   cnt;
  } ras_step_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Pop first, then push. A call and a return together therefore replace
  // the top entry and leave the count unchanged. A pop on an empty stack
  // is ignored. A push on a full stack overwrites the oldest entry.
  function automatic ras_step_t ras_step(input logic [SPW-1:0] sp,
                                         input logic [SPW:0]   cnt,
                                         input logic           push,
                                         input logic           pop);
    ras_step_t      r;
    logic [SPW-1:0] s;
    logic [SPW:0]   c;
    s = sp;
    c = cnt;
    if (pop && (c != '0)) begin
      s = s - 1'b1;
      c = c - 1'b1;
    end
    r.wr   = push;
    r.widx = s;
    if (push) begin
      s = s + 1'b1;
      if (c != RAS_FULL) c = c + 1'b1;
    end
    r.sp  = s;
    r.cnt = c;
    return r;
  endfunction

  logic [XLEN-1:0] spec_stk_reg [RAS_DEPTH];
  logic [XLEN-1:0] com_stk_reg  [RAS_DEPTH];
  logic [SPW-1:0]  spec_sp_reg, com_sp_reg;
  logic [SPW:0]    spec_cnt_reg, com_cnt_reg;

  logic            if_call, if_ret, ex_call, ex_ret;
  logic [SPW-1:0]  top_ptr;
  logic [XLEN-1:0] if_link_addr, ex_link_addr;
  ras_step_t       spec_step, com_step;

  assign if_call = (if_jal | if_jalr) & is_link(inst_if_i[11:7]);
  assign if_ret  = if_jalr & is_link(inst_if_i[19:15]) &
                   ~(is_link(inst_if_i[11:7]) & (inst_if_i[11:7] == inst_if_i[19:15]));
  assign ex_call = (ex_jal | ex_jalr) & is_link(inst_ex_i[11:7]);
  assign ex_ret  = ex_jalr & is_link(inst_ex_i[19:15]) &
                   ~(is_link(inst_ex_i[11:7]) & (inst_ex_i[11:7] == inst_ex_i[19:15]));

  assign if_link_addr = pc_if_i + XLEN'(4);
  assign ex_link_addr = pc_ex_i + XLEN'(4);

  assign spec_step = ras_step(spec_sp_reg, spec_cnt_reg, if_call, if_ret);
  assign com_step  = ras_step(com_sp_reg, com_cnt_reg,
                              ex_valid_i & ex_call, ex_valid_i & ex_ret);

  assign top_ptr = spec_sp_reg - 1'b1;
  assign ras_hit = if_ret && (spec_cnt_reg != '0);
  assign ras_top = spec_stk_reg[top_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_sp_reg  <= '0;
      spec_cnt_reg <= '0;
      com_sp_reg   <= '0;
      com_cnt_reg  <= '0;
    end else if (!stall_i) begin
      com_sp_reg  <= com_step.sp;
      com_cnt_reg <= com_step.cnt;
      // On a flush the speculative copy restarts from the committed state,
      // including this cycle's EX update. Any IF push or pop is dropped.
      if (flush) begin
        spec_sp_reg  <= com_step.sp;
        spec_cnt_reg <= com_step.cnt;
      end else begin
        spec_sp_reg  <= spec_step.sp;
        spec_cnt_reg <= spec_step.cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall_i) begin
      if (com_step.wr) com_stk_reg[com_step.widx] <= ex_link_addr;
      if (flush) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
          spec_stk_reg[i] <= (com_step.wr && (com_step.widx == SPW'(i)))
                             ? ex_link_addr : com_stk_reg[i];
        end
      end else if (spec_step.wr) begin
        spec_stk_reg[spec_step.widx] <= if_link_addr;
      end
    end
  end
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif

  // ---------------------------------------------------------------------------
  // IF prediction and EX check
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pred_pc, expected_pc;

  always_comb begin
    pred_pc = pc_if_i + XLEN'(4);
    if (ras_hit)
      pred_pc = ras_top;
    else if ((if_jal || if_jalr) && if_hit)
      pred_pc = btb_tgt_reg[if_idx];
    else if (if_br && if_hit && btb_ctr_reg[if_idx][CTR_BITS-1])
      pred_pc = btb_tgt_reg[if_idx];
  end

  assign expected_pc = br_taken_i ? br_target_i : (pc_ex_i + XLEN'(4));
  // Gated by reset so that no flush is seen while state is being cleared.
  assign flush       = ~reset & ex_valid_i & ex_cf & (pc_id_i != expected_pc);
  assign flush_o     = flush;
  assign next_pc_o   = flush ? expected_pc : pred_pc;

  // ---------------------------------------------------------------------------
  // BTB update
  // ---------------------------------------------------------------------------
  logic                btb_we;
  logic [CTR_BITS-1:0] ctr_cur, ctr_next;

  assign btb_we  = ex_valid_i & ~stall_i & ex_cf;
  assign ctr_cur = btb_ctr_reg[ex_idx];

  always_comb begin
    ctr_next = br_taken_i ? CTR_WT : CTR_WNT;
    if (ex_hit) begin
      if (br_taken_i)
        ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
      else
        ctr_next = (ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_reg[i] <= 1'b0;
        btb_ctr_reg[i]   <= CTR_WNT;
      end
    end else if (btb_we) begin
      btb_valid_reg[ex_idx] <= 1'b1;
      btb_ctr_reg[ex_idx]   <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_reg[ex_idx] <= ex_tag;
      btb_tgt_reg[ex_idx] <= br_target_i;
    end
  end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// -----------------------------------------------------------------------------
// tb_bpu_btb_ras -- scoreboard bench for bpu_btb_ras with default parameters.
//
// Each transaction drives one cycle of IF/EX inputs just after a rising edge
// and pushes the expected next_pc_o/flush_o onto a queue. A monitor pops the
// queue on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_bpu_btb_ras;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] JAL_X0 = 32'h0000_006F;
  localparam logic [31:0] JAL_X1 = 32'h0000_00EF;
  localparam logic [31:0] RET    = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic [31:0] pc_if_i = '0;
  logic [31:0] inst_if_i = NOP;
  logic [31:0] pc_id_i = '0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] pc_ex_i = '0;
  logic [31:0] inst_ex_i = NOP;
  logic [31:0] br_target_i = '0;
  logic        br_taken_i = 1'b0;
  logic [31:0] next_pc_o;
  logic        flush_o;

  bpu_btb_ras dut (
    .clk        (clk),
    .reset      (reset),
    .stall_i    (stall_i),
    .pc_if_i    (pc_if_i),
    .inst_if_i  (inst_if_i),
    .pc_id_i    (pc_id_i),
    .ex_valid_i (ex_valid_i),
    .pc_ex_i    (pc_ex_i),
    .inst_ex_i  (inst_ex_i),
    .br_target_i(br_target_i),
    .br_taken_i (br_taken_i),
    .next_pc_o  (next_pc_o),
    .flush_o    (flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        fl;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t mon_it;
  int       checks = 0;
  int       errors = 0;
  logic     rst_drv = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic st,
                       input logic [31:0] pif, input logic [31:0] iif,
                       input logic exv, input logic [31:0] pex, input logic [31:0] iex,
                       input logic [31:0] pid, input logic [31:0] tgt, input logic tk,
                       input logic [31:0] enpc, input logic efl);
    sb_item_t it;
    @(posedge clk);
    #1;
    reset       = rst_drv;
    stall_i     = st;
    pc_if_i     = pif;
    inst_if_i   = iif;
    ex_valid_i  = exv;
    pc_ex_i     = pex;
    inst_ex_i   = iex;
    pc_id_i     = pid;
    br_target_i = tgt;
    br_taken_i  = tk;
    it.tag = tag;
    it.npc = enpc;
    it.fl  = efl;
    sb_q.push_back(it);
  endtask

  task automatic fetch(input string tag, input logic [31:0] pif,
                       input logic [31:0] iif, input logic [31:0] enpc);
    drive(tag, 1'b0, pif, iif, 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, enpc, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pif, input logic [31:0] iif,
                         input logic [31:0] pex, input logic [31:0] iex,
                         input logic [31:0] pid, input logic [31:0] tgt, input logic tk,
                         input logic [31:0] enpc, input logic efl);
    drive(tag, 1'b0, pif, iif, 1'b1, pex, iex, pid, tgt, tk, enpc, efl);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_it = sb_q.pop_front();
      $display("TXN %-10s next_pc=%h flush=%0b exp_pc=%h exp_flush=%0b",
               mon_it.tag, next_pc_o, flush_o, mon_it.npc, mon_it.fl);
      check({mon_it.tag, "_pc"}, next_pc_o, mon_it.npc);
      check({mon_it.tag, "_fl"}, {31'b0, flush_o}, {31'b0, mon_it.fl});
    end
  end

  initial begin
    // Reset is held; a mispredicting EX must not flush.
    drive("rst", 1'b0, 32'h100, BEQ, 1'b1, 32'h200, BEQ, 32'h204, 32'h180, 1'b1, 32'h104, 1'b0);
    rst_drv = 1'b0;
    fetch("idle", 32'h100, NOP, 32'h104);

    // Learning: miss allocates with ctr=2 (taken)
    resolve("learn", 32'h200, BEQ, 32'h200, BEQ, 32'h204, 32'h180, 1'b1, 32'h180, 1'b1);
    fetch("refetch", 32'h200, BEQ, 32'h180);

    // Saturation and the read-old-entry behaviour on a same-index write
    resolve("tk1", 32'h200, BEQ, 32'h200, BEQ, 32'h180, 32'h180, 1'b1, 32'h180, 1'b0); // 2->3
    resolve("tk2", 32'h200, BEQ, 32'h200, BEQ, 32'h180, 32'h180, 1'b1, 32'h180, 1'b0); // 3->3
    resolve("nt1", 32'h200, BEQ, 32'h200, BEQ, 32'h204, 32'h180, 1'b0, 32'h180, 1'b0); // 3->2
    resolve("nt2", 32'h200, BEQ, 32'h200, BEQ, 32'h204, 32'h180, 1'b0, 32'h180, 1'b0); // 2->1
    fetch("ctr1", 32'h200, BEQ, 32'h204);
    resolve("nt3", 32'h200, BEQ, 32'h200, BEQ, 32'h204, 32'h180, 1'b0, 32'h204, 1'b0); // 1->0
    resolve("nt4", 32'h200, BEQ, 32'h200, BEQ, 32'h204, 32'h180, 1'b0, 32'h204, 1'b0); // 0->0
    resolve("tk3", 32'h200, BEQ, 32'h200, BEQ, 32'h180, 32'h180, 1'b1, 32'h204, 1'b0); // 0->1
    fetch("floor", 32'h200, BEQ, 32'h204);
    resolve("tk4", 32'h200, BEQ, 32'h200, BEQ, 32'h180, 32'h180, 1'b1, 32'h204, 1'b0); // 1->2
    fetch("ctr2", 32'h200, BEQ, 32'h180);

    // Tag conflict at the same index, then replacement
    fetch("alias", 32'h1200, BEQ, 32'h1204);
    resolve("repl", 32'h100, NOP, 32'h1200, BEQ, 32'h180, 32'h1280, 1'b0, 32'h1204, 1'b1);
    fetch("evict", 32'h200, BEQ, 32'h204);
    fetch("alias2", 32'h1200, BEQ, 32'h1204);

    // Unconditional jump learned from the BTB
    resolve("jal_l", 32'h100, NOP, 32'h400, JAL_X0, 32'h404, 32'h800, 1'b1, 32'h800, 1'b1);
    fetch("jal_h", 32'h400, JAL_X0, 32'h800);

    // Stall: flush is still visible, but nothing is written
    drive("stall", 1'b1, 32'h600, BEQ, 1'b1, 32'h600, BEQ, 32'h604, 32'h700, 1'b1, 32'h700, 1'b1);
    fetch("stall_c", 32'h600, BEQ, 32'h604);

`ifdef BPU_RAS_EN
    fetch("ras_call", 32'h300, JAL_X1, 32'h304);
    fetch("ras_ret", 32'h500, RET, 32'h304);
    // Recovery: speculative pushes are discarded by a flush
    fetch("rec_call", 32'h320, JAL_X1, 32'h324);
    resolve("rec_fl", 32'h330, JAL_X1, 32'h640, BEQ, 32'h644, 32'h700, 1'b1, 32'h700, 1'b1);
    fetch("rec_ret", 32'h500, RET, 32'h504);
    // Nine nested calls overflow an 8-deep stack
    for (int k = 0; k < 9; k++)
      fetch($sformatf("call%0d", k), 32'h1000 + 32'(8 * k), JAL_X1, 32'h1004 + 32'(8 * k));
    for (int j = 0; j < 8; j++)
      fetch($sformatf("ret%0d", j), 32'h500, RET, 32'h1044 - 32'(8 * j));
    fetch("ret8", 32'h500, RET, 32'h504);
    // A stalled call does not push
    drive("st_call", 1'b1, 32'h340, JAL_X1, 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'h344, 1'b0);
    fetch("st_ret", 32'h500, RET, 32'h504);
    // The committed push becomes visible after a flush
    resolve("com_call", 32'h700, NOP, 32'h300, JAL_X1, 32'h500, 32'h500, 1'b1, 32'h704, 1'b0);
    resolve("com_fl", 32'h100, NOP, 32'h640, BEQ, 32'h644, 32'h700, 1'b1, 32'h700, 1'b1);
    fetch("com_ret", 32'h500, RET, 32'h304);
`else
    // Without the RAS, a return is predicted like any other jump
    fetch("ret_miss", 32'h500, RET, 32'h504);
    resolve("ret_l", 32'h100, NOP, 32'h500, RET, 32'h504, 32'h304, 1'b1, 32'h304, 1'b1);
    fetch("ret_btb", 32'h500, RET, 32'h304);
`endif

    // Reset mid-operation discards learned state immediately
    fetch("pre_rst", 32'h400, JAL_X0, 32'h800);
    rst_drv = 1'b1;
    fetch("rst_mid", 32'h400, JAL_X0, 32'h404);
    rst_drv = 1'b0;
    fetch("post_rst", 32'h400, JAL_X0, 32'h404);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() != 0) check("drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
